// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu : registered WIDTH-bit arithmetic/logic unit with status flags
// rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // One extra bit so bit WIDTH is the add carry-out / subtract borrow.
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] result_d;
  logic             carry_d;
  logic             overflow_d;
  logic [WIDTH-1:0] result_q;
  logic             out_valid_q;
  logic             carry_q;
  logic             zero_q;
  logic             negative_q;
  logic             overflow_q;

  assign w_sum  = {1'b0, A} + {1'b0, B};
  assign w_diff = {1'b0, A} - {1'b0, B};

  always_comb begin
    result_d   = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    unique case (sel)
      OP_ADD: begin
        result_d   = w_sum[WIDTH-1:0];
        carry_d    = w_sum[WIDTH];
        overflow_d = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        result_d   = w_diff[WIDTH-1:0];
        carry_d    = w_diff[WIDTH];
        overflow_d = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: result_d = A & B;
      OP_OR:  result_d = A | B;
      OP_NOT: result_d = ~A;
      OP_XOR: result_d = A ^ B;
      OP_SHL: begin
        result_d = {A[WIDTH-2:0], 1'b0};
        carry_d  = A[WIDTH-1];
      end
      OP_SHR: begin
        result_d = {1'b0, A[WIDTH-1:1]};
        carry_d  = A[0];
      end
      default: result_d = '0;
    endcase
  end

  // Flags only update with an accepted op, so they always describe result_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        result_q   <= result_d;
        carry_q    <= carry_d;
        zero_q     <= ~|result_d;
        negative_q <= result_d[WIDTH-1];
        overflow_q <= overflow_d;
      end
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu : randomized + directed self-checking bench for alu
// rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         n;
    logic         v;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [2:0]   sel = '0;
  logic [W-1:0] result;
  logic         out_valid;
  logic         carry;
  logic         zero;
  logic         negative;
  logic         overflow;

  int   total = 0;
  int   bad = 0;
  bit   started = 1'b0;
  res_t exp_q = '0;
  logic exp_valid_q = 1'b0;

  alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .sel      (sel),
    .result   (result),
    .out_valid(out_valid),
    .carry    (carry),
    .zero     (zero),
    .negative (negative),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference: integer arithmetic on unsigned and signed interpretations.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] s);
    res_t o;
    int ua, ub, sa, sb, md, hf, t, ss;
    md = 1 << W;
    hf = md / 2;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= hf) ? ua - md : ua;
    sb = (ub >= hf) ? ub - md : ub;
    o = '0;
    case (s)
      3'd0: begin
        t = ua + ub;  o.r = W'(t % md); o.c = (t >= md);
        ss = sa + sb; o.v = (ss < -hf) || (ss >= hf);
      end
      3'd1: begin
        t = ua - ub;  o.r = W'((t + md) % md); o.c = (ua < ub);
        ss = sa - sb; o.v = (ss < -hf) || (ss >= hf);
      end
      3'd2: o.r = a & b;
      3'd3: o.r = a | b;
      3'd4: o.r = ~a;
      3'd5: o.r = a ^ b;
      3'd6: begin o.r = W'((ua * 2) % md); o.c = (ua >= hf); end
      default: begin o.r = W'(ua / 2); o.c = (ua % 2 == 1); end
    endcase
    o.z = (o.r == '0);
    o.n = (int'(o.r) >= hf);
    return o;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q       <= '0;
      exp_valid_q <= 1'b0;
    end else begin
      exp_valid_q <= in_valid;
      if (in_valid) exp_q <= model(A, B, sel);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      total++;
      if ({out_valid, result, carry, zero, negative, overflow} !==
          {exp_valid_q, exp_q.r, exp_q.c, exp_q.z, exp_q.n, exp_q.v}) begin
        bad++;
        $display("FAIL model_cmp t=%0t got v=%b r=%b c=%b z=%b n=%b o=%b want v=%b r=%b c=%b z=%b n=%b o=%b",
                 $time, out_valid, result, carry, zero, negative, overflow,
                 exp_valid_q, exp_q.r, exp_q.c, exp_q.z, exp_q.n, exp_q.v);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    A = a;
    B = b;
    sel = s;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    sel = 3'($urandom);
  endtask

  task automatic chk_now(input string name, input logic v, input logic [W-1:0] r,
                         input logic c, input logic z, input logic n, input logic o);
    total++;
    if ({out_valid, result, carry, zero, negative, overflow} !== {v, r, c, z, n, o}) begin
      bad++;
      $display("FAIL %s got v=%b r=%b c=%b z=%b n=%b o=%b want v=%b r=%b c=%b z=%b n=%b o=%b",
               name, out_valid, result, carry, zero, negative, overflow, v, r, c, z, n, o);
    end
  endtask

  task automatic chk(input string name, input logic v, input logic [W-1:0] r,
                     input logic c, input logic z, input logic n, input logic o);
    @(negedge clk);
    chk_now(name, v, r, c, z, n, o);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk_now("reset_state", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    started = 1'b1;

    // Opcode sweep, back-to-back; each check sees the previous request.
    issue(4'b0101, 4'b0011, 3'd0);
    issue(4'b0101, 4'b0011, 3'd1); chk("add_5_3", 1, 4'b1000, 0, 0, 1, 1);
    issue(4'b0101, 4'b0011, 3'd2); chk("sub_5_3", 1, 4'b0010, 0, 0, 0, 0);
    issue(4'b0101, 4'b0011, 3'd3); chk("and_5_3", 1, 4'b0001, 0, 0, 0, 0);
    issue(4'b0101, 4'b0011, 3'd4); chk("or_5_3",  1, 4'b0111, 0, 0, 0, 0);
    issue(4'b1111, 4'b0001, 3'd0); chk("not_5",   1, 4'b1010, 0, 0, 1, 0);
    issue(4'b0000, 4'b0001, 3'd1); chk("add_f_1", 1, 4'b0000, 1, 1, 0, 0);
    issue(4'b1000, 4'b0001, 3'd1); chk("sub_0_1", 1, 4'b1111, 1, 0, 1, 0);
    issue(4'b1001, 4'b0110, 3'd5); chk("sub_8_1", 1, 4'b0111, 0, 0, 0, 1);
    issue(4'b1001, 4'b0110, 3'd6); chk("xor_9_6", 1, 4'b1111, 0, 0, 1, 0);
    issue(4'b1001, 4'b0110, 3'd7); chk("shl_9",   1, 4'b0010, 1, 0, 0, 0);
    idle();                        chk("shr_9",   1, 4'b0100, 1, 0, 0, 0);
    idle();                        chk("gated_1", 0, 4'b0100, 1, 0, 0, 0);
    idle();                        chk("gated_2", 0, 4'b0100, 1, 0, 0, 0);

    // Alternating ADD/AND for 8 cycles, no bubbles allowed.
    for (int i = 0; i < 8; i++) issue(W'($urandom), W'($urandom), (i % 2 == 0) ? 3'd0 : 3'd2);
    idle();

    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      in_valid = ($urandom_range(0, 3) != 0);
      A = W'($urandom);
      B = W'($urandom);
      sel = 3'($urandom);
    end

    // Asynchronous reset mid-cycle with a non-zero result pending.
    issue(4'b0001, 4'b0001, 3'd0);
    issue(4'b0111, 4'b0001, 3'd0);
    #3;
    chk_now("pre_reset", 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_now("async_reset", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk_now("reset_hold", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    A = 4'b0011;
    B = 4'b0100;
    sel = 3'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("first_after_reset", 1, 4'b0111, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
